// File: rtl/rs_alu.sv
// ALU reservation station: holds up to DEPTH dispatched instructions, snoops the
// CDB for pending operands and issues the lowest-index operand-complete entry.
module rs_alu #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 4,
  parameter int OP_W  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       disp_vld,
  output logic                       disp_rdy,
  input  logic [OP_W-1:0]            disp_op,
  input  logic [TAG_W-1:0]           disp_dst_tag,
  input  logic                       disp_rs1_busy,
  input  logic [TAG_W-1:0]           disp_rs1_tag,
  input  logic [31:0]                disp_rs1_data,
  input  logic                       disp_rs2_busy,
  input  logic [TAG_W-1:0]           disp_rs2_tag,
  input  logic [31:0]                disp_rs2_data,
  input  logic                       cdb_wr,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [31:0]                cdb_wdata,
  output logic                       iss_vld,
  input  logic                       iss_rdy,
  output logic [OP_W-1:0]            iss_op,
  output logic [31:0]                iss_src1,
  output logic [31:0]                iss_src2,
  output logic [TAG_W-1:0]           iss_dst_tag,
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] dst;
    logic             rdy1;
    logic [TAG_W-1:0] tag1;
    logic [31:0]      data1;
    logic             rdy2;
    logic [TAG_W-1:0] tag2;
    logic [31:0]      data2;
  } entry_t;

  entry_t           ent [DEPTH];
  entry_t           new_ent;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] iss_idx;
  logic             disp_fire;
  logic             iss_fire;
  logic             cdb_hit;

  // Tag 0 means "no producer", so a broadcast on it must never wake anything.
  assign cdb_hit = cdb_wr && (cdb_tag != '0);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    disp_rdy = 1'b0;
    iss_vld  = 1'b0;
    free_idx = '0;
    iss_idx  = '0;
    // Scan high to low so the lowest matching index is the one left standing.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent[i].valid) begin
        disp_rdy = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (ent[i].valid && ent[i].rdy1 && ent[i].rdy2) begin
        iss_vld = 1'b1;
        iss_idx = IDX_W'(i);
      end
    end
  end

  assign disp_fire = disp_vld && disp_rdy && !flush;
  assign iss_fire  = iss_vld && iss_rdy;

  assign iss_op      = iss_vld ? ent[iss_idx].op    : '0;
  assign iss_src1    = iss_vld ? ent[iss_idx].data1 : '0;
  assign iss_src2    = iss_vld ? ent[iss_idx].data2 : '0;
  assign iss_dst_tag = iss_vld ? ent[iss_idx].dst   : '0;

  always_comb begin
    new_ent       = '0;
    new_ent.valid = 1'b1;
    new_ent.op    = disp_op;
    new_ent.dst   = disp_dst_tag;
    if (!disp_rs1_busy) begin
      new_ent.rdy1  = 1'b1;
      new_ent.data1 = disp_rs1_data;
    end else if (cdb_hit && cdb_tag == disp_rs1_tag) begin
      new_ent.rdy1  = 1'b1;
      new_ent.data1 = cdb_wdata;
    end else begin
      new_ent.tag1  = disp_rs1_tag;
    end
    if (!disp_rs2_busy) begin
      new_ent.rdy2  = 1'b1;
      new_ent.data2 = disp_rs2_data;
    end else if (cdb_hit && cdb_tag == disp_rs2_tag) begin
      new_ent.rdy2  = 1'b1;
      new_ent.data2 = cdb_wdata;
    end else begin
      new_ent.tag2  = disp_rs2_tag;
    end
  end

  // NOTE: the entry array is reset in full (not just valid bits) so tags and data read 0 after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      occ <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
      occ <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (iss_fire && iss_idx == IDX_W'(i)) ent[i].valid <= 1'b0;
        if (ent[i].valid && !ent[i].rdy1 && cdb_hit && ent[i].tag1 == cdb_tag) begin
          ent[i].rdy1  <= 1'b1;
          ent[i].data1 <= cdb_wdata;
          ent[i].tag1  <= '0;
        end
        if (ent[i].valid && !ent[i].rdy2 && cdb_hit && ent[i].tag2 == cdb_tag) begin
          ent[i].rdy2  <= 1'b1;
          ent[i].data2 <= cdb_wdata;
          ent[i].tag2  <= '0;
        end
      end
      // Dispatch only targets a free entry, so it never collides with the issued one.
      if (disp_fire) ent[free_idx] <= new_ent;
      occ <= occ + OCC_W'(disp_fire) - OCC_W'(iss_fire);
    end
  end

endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu: expected issue records are queued at dispatch and
// popped when the station presents them on the issue port.
module tb_rs_alu;

  localparam int TAG_W = 4;
  localparam int DEPTH = 4;
  localparam int OP_W  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             disp_vld;
  logic             disp_rdy;
  logic [OP_W-1:0]  disp_op;
  logic [TAG_W-1:0] disp_dst_tag;
  logic             disp_rs1_busy;
  logic [TAG_W-1:0] disp_rs1_tag;
  logic [31:0]      disp_rs1_data;
  logic             disp_rs2_busy;
  logic [TAG_W-1:0] disp_rs2_tag;
  logic [31:0]      disp_rs2_data;
  logic             cdb_wr;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_wdata;
  logic             iss_vld;
  logic             iss_rdy;
  logic [OP_W-1:0]  iss_op;
  logic [31:0]      iss_src1;
  logic [31:0]      iss_src2;
  logic [TAG_W-1:0] iss_dst_tag;
  logic [2:0]       occ;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [31:0]      src1;
    logic [31:0]      src2;
    logic [TAG_W-1:0] dst;
  } iss_t;

  iss_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  rs_alu #(.TAG_W(TAG_W), .DEPTH(DEPTH), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_vld(disp_vld), .disp_rdy(disp_rdy), .disp_op(disp_op),
    .disp_dst_tag(disp_dst_tag),
    .disp_rs1_busy(disp_rs1_busy), .disp_rs1_tag(disp_rs1_tag), .disp_rs1_data(disp_rs1_data),
    .disp_rs2_busy(disp_rs2_busy), .disp_rs2_tag(disp_rs2_tag), .disp_rs2_data(disp_rs2_data),
    .cdb_wr(cdb_wr), .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata),
    .iss_vld(iss_vld), .iss_rdy(iss_rdy), .iss_op(iss_op),
    .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_dst_tag(iss_dst_tag),
    .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare the presented issue record against the oldest scoreboard entry.
  task automatic check_issue(input string tag);
    iss_t exp;
    iss_t obs;
    check({tag, "_vld"}, 80'(iss_vld), 80'(1));
    obs = '{op: iss_op, src1: iss_src1, src2: iss_src2, dst: iss_dst_tag};
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed issue %0h expected empty scoreboard", tag, obs);
    end else begin
      exp = sb.pop_front();
      check(tag, 80'(obs), 80'(exp));
    end
  endtask

  // Inputs change #1 after the rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] dst,
                          input logic b1, input logic [TAG_W-1:0] t1, input logic [31:0] d1,
                          input logic b2, input logic [TAG_W-1:0] t2, input logic [31:0] d2);
    disp_vld      = 1'b1;
    disp_op       = op;
    disp_dst_tag  = dst;
    disp_rs1_busy = b1;
    disp_rs1_tag  = t1;
    disp_rs1_data = d1;
    disp_rs2_busy = b2;
    disp_rs2_tag  = t2;
    disp_rs2_data = d2;
  endtask

  task automatic set_cdb(input logic wr, input logic [TAG_W-1:0] tag, input logic [31:0] data);
    cdb_wr    = wr;
    cdb_tag   = tag;
    cdb_wdata = data;
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    disp_vld = 1'b0;
    set_disp(4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    disp_vld = 1'b0;
    set_cdb(1'b0, 4'd0, 32'd0);
    iss_rdy = 1'b0;

    // Reset values
    #2;
    check("rst_disp_rdy", 80'(disp_rdy), 80'(1));
    check("rst_iss_vld", 80'(iss_vld), 80'(0));
    check("rst_outs", 80'({iss_op, iss_src1, iss_src2, iss_dst_tag}), 80'(0));
    check("rst_occ", 80'(occ), 80'(0));
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Plain dispatch with both operands available
    set_disp(4'd3, 4'd5, 1'b0, 4'd0, 32'h10, 1'b0, 4'd0, 32'h20);
    sb.push_back('{op: 4'd3, src1: 32'h10, src2: 32'h20, dst: 4'd5});
    check("t1_not_yet", 80'(iss_vld), 80'(0));
    tick();
    disp_vld = 1'b0;
    check("t1_occ1", 80'(occ), 80'(1));
    check_issue("t1_issue");
    iss_rdy = 1'b1;
    tick();
    iss_rdy = 1'b0;
    check("t1_occ0", 80'(occ), 80'(0));
    check("t1_idle", 80'(iss_vld), 80'(0));

    // rs1 waits on tag 2, broadcast two cycles after dispatch
    set_disp(4'd1, 4'd6, 1'b1, 4'd2, 32'hDEAD, 1'b0, 4'd0, 32'h7);
    sb.push_back('{op: 4'd1, src1: 32'hABCD, src2: 32'h7, dst: 4'd6});
    tick();
    disp_vld = 1'b0;
    check("t2_wait0", 80'(iss_vld), 80'(0));
    set_cdb(1'b1, 4'd0, 32'h1234);
    tick();
    check("t2_tag0_nomatch", 80'(iss_vld), 80'(0));
    set_cdb(1'b1, 4'd2, 32'hABCD);
    check("t2_same_cycle", 80'(iss_vld), 80'(0));
    tick();
    set_cdb(1'b0, 4'd0, 32'd0);
    check_issue("t2_issue");
    iss_rdy = 1'b1;
    tick();
    iss_rdy = 1'b0;
    check("t2_occ0", 80'(occ), 80'(0));

    // Same-cycle CDB bypass on rs2
    set_disp(4'd2, 4'd7, 1'b0, 4'd0, 32'h1, 1'b1, 4'd3, 32'hBAD);
    set_cdb(1'b1, 4'd3, 32'h55);
    sb.push_back('{op: 4'd2, src1: 32'h1, src2: 32'h55, dst: 4'd7});
    tick();
    disp_vld = 1'b0;
    set_cdb(1'b0, 4'd0, 32'd0);
    check_issue("t3_bypass");
    iss_rdy = 1'b1;
    tick();
    iss_rdy = 1'b0;

    // Fill all entries waiting on tag 7, then a rejected fifth dispatch
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(4'(i + 4), 4'(i + 8), 1'b1, 4'd7, 32'h0, 1'b0, 4'd0, 32'(32'h100 + i));
      sb.push_back('{op: 4'(i + 4), src1: 32'h7777, src2: 32'(32'h100 + i), dst: 4'(i + 8)});
      tick();
    end
    disp_vld = 1'b0;
    check("t4_full_rdy", 80'(disp_rdy), 80'(0));
    check("t4_occ4", 80'(occ), 80'(4));
    check("t4_none_ready", 80'(iss_vld), 80'(0));
    set_disp(4'd15, 4'd12, 1'b0, 4'd0, 32'h9, 1'b0, 4'd0, 32'h9);
    tick();
    disp_vld = 1'b0;
    check("t4_ignored_occ", 80'(occ), 80'(4));
    set_cdb(1'b1, 4'd7, 32'h7777);
    tick();
    set_cdb(1'b0, 4'd0, 32'd0);
    iss_rdy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check_issue($sformatf("t4_order%0d", i));
      tick();
    end
    iss_rdy = 1'b0;
    check("t4_drained_occ", 80'(occ), 80'(0));
    check("t4_drained_vld", 80'(iss_vld), 80'(0));

    // Back-pressure: outputs hold while iss_rdy is low
    set_disp(4'd9, 4'd13, 1'b0, 4'd0, 32'hCAFE, 1'b0, 4'd0, 32'hF00D);
    sb.push_back('{op: 4'd9, src1: 32'hCAFE, src2: 32'hF00D, dst: 4'd13});
    tick();
    disp_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t5_hold%0d", i),
            80'({iss_vld, iss_op, iss_src1, iss_src2, iss_dst_tag, occ}),
            80'({1'b1, 4'd9, 32'hCAFE, 32'hF00D, 4'd13, 3'd1}));
      tick();
    end
    check_issue("t5_issue");
    // Issue and dispatch in one cycle keep occupancy unchanged
    iss_rdy = 1'b1;
    set_disp(4'd10, 4'd14, 1'b0, 4'd0, 32'h11, 1'b0, 4'd0, 32'h22);
    sb.push_back('{op: 4'd10, src1: 32'h11, src2: 32'h22, dst: 4'd14});
    tick();
    disp_vld = 1'b0;
    check("t5_occ_same", 80'(occ), 80'(1));
    check_issue("t5_next");
    tick();
    iss_rdy = 1'b0;
    check("t5_occ0", 80'(occ), 80'(0));

    // Flush with a simultaneous dispatch
    for (int i = 0; i < 3; i++) begin
      set_disp(4'd1, 4'(i + 1), 1'b1, 4'd9, 32'h0, 1'b0, 4'd0, 32'h0);
      tick();
    end
    disp_vld = 1'b0;
    check("t6_occ3", 80'(occ), 80'(3));
    flush = 1'b1;
    set_disp(4'd2, 4'd15, 1'b0, 4'd0, 32'h3, 1'b0, 4'd0, 32'h4);
    tick();
    flush = 1'b0;
    disp_vld = 1'b0;
    check("t6_flush", 80'({occ, iss_vld, disp_rdy}), 80'({3'd0, 1'b0, 1'b1}));
    set_cdb(1'b1, 4'd9, 32'h99);
    tick();
    set_cdb(1'b0, 4'd0, 32'd0);
    check("t6_no_revive", 80'({occ, iss_vld}), 80'({3'd0, 1'b0}));

    // Asynchronous reset mid-cycle with a ready entry pending
    set_disp(4'd6, 4'd3, 1'b0, 4'd0, 32'h66, 1'b0, 4'd0, 32'h77);
    tick();
    disp_vld = 1'b0;
    check("t7_pre_rst", 80'({iss_vld, iss_dst_tag, occ}), 80'({1'b1, 4'd3, 3'd1}));
    #2;
    rst = 1'b0;
    #1;
    check("t7_async_rst", 80'({iss_vld, iss_op, iss_src1, iss_src2, iss_dst_tag, occ, disp_rdy}),
          80'({1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 3'd0, 1'b1}));
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("t7_post_rst", 80'({iss_vld, occ}), 80'({1'b0, 3'd0}));
    check("sb_empty", 80'(sb.size()), 80'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
